// File: rtl/bridge_cmd_pkg.sv
// Shared types and constants for the UART-AXI4-Lite bridge command sequencer.
// Contents:
//   seq_state_e  - sequencer FSM states
//   STATUS_*     - response status codes produced by the sequencer itself
//   desc_t       - parsed-frame descriptor as queued between parser and sequencer
//                  (buf_id is carried at its widest supported size, 8 bits)
package bridge_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE_AXI  = 3'd1,
        ST_WAIT_AXI   = 3'd2,
        ST_ISSUE_RESP = 3'd3,
        ST_WAIT_RESP  = 3'd4
    } seq_state_e;

    localparam logic [7:0] STATUS_OK          = 8'h00;
    localparam logic [7:0] STATUS_AXI_TIMEOUT = 8'h04;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic        err;
        logic [7:0]  err_status;
        logic [7:0]  buf_id;
    } desc_t;

    // Bit 7 of the command byte selects a read transaction.
    function automatic logic cmd_is_read(input logic [7:0] cmd);
        return cmd[7];
    endfunction

endpackage

// File: rtl/bridge_desc_fifo.sv
// Synchronous descriptor FIFO for the bridge command sequencer.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   push_i / data_i   - write request and descriptor (ignored while full)
//   pop_i  / data_o   - read request (ignored while empty) and head descriptor
//   full_o, empty_o   - occupancy flags
//   level_o           - number of stored descriptors
module bridge_desc_fifo
    import bridge_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  desc_t                    data_i,
    input  logic                     pop_i,
    output desc_t                    data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    desc_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full_o    = (level_q == FULL_LVL);
    assign empty_o   = (level_q == '0);
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    assign data_o    = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // Storage array: written on accepted push only, needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop keeps the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/bridge_cmd_sequencer.sv
// Control sequencer of the UART-AXI4-Lite bridge. Queues parsed-frame
// descriptors, drives the AXI4-Lite master with a response-path timeout,
// hands results to the frame builder, releases payload buffers and keeps
// saturating per-class statistics.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   desc_*                      - descriptor push interface from the parser
//   axi_start_o/axi_abort_o     - one-cycle pulses to the AXI master
//   axi_cmd/addr/buf_id_o       - current frame, held while the AXI access runs
//   axi_done_i/status/rd_count  - AXI master completion
//   resp_*                      - frame-builder request, held until resp_done_i
//   buf_release_o/_id_o         - buffer-pool release pulse
//   queue_level_o, busy_o       - queue occupancy (excluding current), activity
//   stats_clear_i, *_count_o    - statistics clear and counters
// Build option: define BRIDGE_CMD_SEQ_RETRY_EN to re-issue failed or timed-out
// AXI accesses up to MAX_RETRY times per frame.
module bridge_cmd_sequencer
    import bridge_cmd_pkg::*;
#(
    parameter int QUEUE_DEPTH      = 4,
    parameter int BUF_ID_W         = 2,
    parameter int STAT_WIDTH       = 16,
    parameter int AXI_WAIT_TIMEOUT = 2000,
    parameter int MAX_RETRY        = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           desc_valid_i,
    output logic                           desc_ready_o,
    input  logic [7:0]                     desc_cmd_i,
    input  logic [31:0]                    desc_addr_i,
    input  logic                           desc_err_i,
    input  logic [7:0]                     desc_err_status_i,
    input  logic [BUF_ID_W-1:0]            desc_buf_id_i,
    output logic                           axi_start_o,
    output logic                           axi_abort_o,
    output logic [7:0]                     axi_cmd_o,
    output logic [31:0]                    axi_addr_o,
    output logic [BUF_ID_W-1:0]            axi_buf_id_o,
    input  logic                           axi_done_i,
    input  logic [7:0]                     axi_status_i,
    input  logic [5:0]                     axi_rd_count_i,
    output logic                           resp_start_o,
    output logic [7:0]                     resp_status_o,
    output logic [7:0]                     resp_cmd_o,
    output logic [31:0]                    resp_addr_o,
    output logic                           resp_is_read_o,
    output logic [5:0]                     resp_count_o,
    output logic [BUF_ID_W-1:0]            resp_buf_id_o,
    input  logic                           resp_done_i,
    output logic                           buf_release_o,
    output logic [BUF_ID_W-1:0]            buf_release_id_o,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_level_o,
    output logic                           busy_o,
    input  logic                           stats_clear_i,
    output logic [STAT_WIDTH-1:0]          wr_count_o,
    output logic [STAT_WIDTH-1:0]          rd_count_o,
    output logic [STAT_WIDTH-1:0]          err_count_o,
    output logic [7:0]                     retry_count_o
);

`ifdef BRIDGE_CMD_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam int              TW          = $clog2(AXI_WAIT_TIMEOUT + 1);
    localparam logic [TW-1:0]   TMR_LAST    = TW'(AXI_WAIT_TIMEOUT - 1);
    localparam logic [7:0]      RETRY_LIMIT = 8'(MAX_RETRY);

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    seq_state_e              state_q, state_d;
    desc_t                   cur_q, cur_d;
    logic [TW-1:0]           tmr_q, tmr_d;
    logic [7:0]              status_q, status_d;
    logic [5:0]              count_q, count_d;
    logic [7:0]              retries_q, retries_d;
    logic [7:0]              retry_total_q, retry_total_d;
    logic [STAT_WIDTH-1:0]   wr_q, wr_d, rd_q, rd_d, err_q, err_d;

    desc_t                   push_desc_s;
    desc_t                   head_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic                    timeout_hit_s;
    logic                    want_retry_s;
    logic                    unused_buf_bits_s;

    assign push_desc_s = '{cmd: desc_cmd_i, addr: desc_addr_i, err: desc_err_i,
                           err_status: desc_err_status_i, buf_id: 8'(desc_buf_id_i)};

    bridge_desc_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (desc_valid_i),
        .data_i  (push_desc_s),
        .pop_i   (state_q == ST_IDLE),
        .data_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (queue_level_o)
    );

    // Timer value TMR_LAST is the AXI_WAIT_TIMEOUT-th cycle after axi_start.
    assign timeout_hit_s = (tmr_q == TMR_LAST);
    // A completion in the same cycle as the timeout takes precedence.
    assign want_retry_s  = RETRY_EN && (retries_q < RETRY_LIMIT) &&
                           (axi_done_i ? (axi_status_i != STATUS_OK) : timeout_hit_s);

    // FSM state register plus frame datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cur_q         <= '0;
            tmr_q         <= '0;
            status_q      <= '0;
            count_q       <= '0;
            retries_q     <= '0;
            retry_total_q <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            tmr_q         <= tmr_d;
            status_q      <= status_d;
            count_q       <= count_d;
            retries_q     <= retries_d;
            retry_total_q <= retry_total_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            err_q         <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = head_s.err ? ST_ISSUE_RESP : ST_ISSUE_AXI;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE_AXI: state_d = ST_WAIT_AXI;
            ST_WAIT_AXI: begin
                if (axi_done_i || timeout_hit_s) begin
                    state_d = want_retry_s ? ST_ISSUE_AXI : ST_ISSUE_RESP;
                end else begin
                    state_d = ST_WAIT_AXI;
                end
            end
            ST_ISSUE_RESP: state_d = ST_WAIT_RESP;
            ST_WAIT_RESP: begin
                if (resp_done_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: frame capture, AXI result, statistics.
    always_comb begin
        cur_d         = cur_q;
        tmr_d         = tmr_q;
        status_d      = status_q;
        count_d       = count_q;
        retries_d     = retries_q;
        retry_total_d = retry_total_q;
        wr_d          = wr_q;
        rd_d          = rd_q;
        err_d         = err_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    cur_d     = head_s;
                    retries_d = 8'd0;
                    status_d  = head_s.err ? head_s.err_status : STATUS_OK;
                    count_d   = 6'd0;
                end else begin
                    cur_d = cur_q;
                end
            end
            ST_ISSUE_AXI: tmr_d = '0;
            ST_WAIT_AXI: begin
                tmr_d = tmr_q + 1'b1;
                if (want_retry_s && (axi_done_i || timeout_hit_s)) begin
                    retries_d     = retries_q + 8'd1;
                    retry_total_d = sat_inc8(retry_total_q);
                end else if (axi_done_i) begin
                    status_d = axi_status_i;
                    count_d  = (cmd_is_read(cur_q.cmd) && (axi_status_i == STATUS_OK))
                               ? axi_rd_count_i : 6'd0;
                end else if (timeout_hit_s) begin
                    status_d = STATUS_AXI_TIMEOUT;
                    count_d  = 6'd0;
                end else begin
                    status_d = status_q;
                end
            end
            ST_WAIT_RESP: begin
                if (resp_done_i) begin
                    // Parse-errored frames are only error-counted.
                    if (cur_q.err) begin
                        err_d = sat_inc(err_q);
                    end else begin
                        if (cmd_is_read(cur_q.cmd)) begin
                            rd_d = sat_inc(rd_q);
                        end else begin
                            wr_d = sat_inc(wr_q);
                        end
                        if (status_q != STATUS_OK) begin
                            err_d = sat_inc(err_q);
                        end else begin
                            err_d = err_q;
                        end
                    end
                end else begin
                    wr_d = wr_q;
                end
            end
            default: begin
                tmr_d = tmr_q;
            end
        endcase
        // Clear overrides any increment in the same cycle.
        if (stats_clear_i) begin
            wr_d          = '0;
            rd_d          = '0;
            err_d         = '0;
            retry_total_d = 8'd0;
        end else begin
            retry_total_d = retry_total_d;
        end
    end

    // Output decode of the one-cycle pulses from the current state.
    always_comb begin
        axi_start_o   = 1'b0;
        axi_abort_o   = 1'b0;
        resp_start_o  = 1'b0;
        buf_release_o = 1'b0;
        case (state_q)
            ST_ISSUE_AXI:  axi_start_o   = 1'b1;
            ST_WAIT_AXI:   axi_abort_o   = timeout_hit_s && !axi_done_i;
            ST_ISSUE_RESP: resp_start_o  = 1'b1;
            ST_WAIT_RESP:  buf_release_o = resp_done_i;
            default:       axi_start_o   = 1'b0;
        endcase
    end

    assign desc_ready_o     = !fifo_full_s;
    assign busy_o           = (state_q != ST_IDLE) || !fifo_empty_s;
    assign axi_cmd_o        = cur_q.cmd;
    assign axi_addr_o       = cur_q.addr;
    assign axi_buf_id_o     = cur_q.buf_id[BUF_ID_W-1:0];
    assign resp_status_o    = status_q;
    assign resp_cmd_o       = cur_q.cmd;
    assign resp_addr_o      = cur_q.addr;
    assign resp_is_read_o   = cmd_is_read(cur_q.cmd) && !cur_q.err;
    assign resp_count_o     = count_q;
    assign resp_buf_id_o    = cur_q.buf_id[BUF_ID_W-1:0];
    assign buf_release_id_o = cur_q.buf_id[BUF_ID_W-1:0];
    assign wr_count_o       = wr_q;
    assign rd_count_o       = rd_q;
    assign err_count_o      = err_q;
    assign retry_count_o    = retry_total_q;

    // Upper descriptor buf_id bits beyond BUF_ID_W are always zero.
    assign unused_buf_bits_s = ^cur_q.buf_id;

endmodule

// File: tb/tb_bridge_cmd_sequencer.sv
// Self-checking bench for bridge_cmd_sequencer: directed scenarios followed by
// randomized frames, checked against a transaction-level reference model.
module tb_bridge_cmd_sequencer;

    localparam int QD = 4;
    localparam int BW = 2;
    localparam int SW = 3;
    localparam int TO = 20;
    localparam int MR = 2;

    logic          clk;
    logic          rst;
    logic          desc_valid, desc_ready, desc_err;
    logic [7:0]    desc_cmd, desc_err_status;
    logic [31:0]   desc_addr;
    logic [BW-1:0] desc_buf_id;
    logic          axi_start, axi_abort, axi_done;
    logic [7:0]    axi_cmd, axi_status;
    logic [31:0]   axi_addr;
    logic [BW-1:0] axi_buf_id;
    logic [5:0]    axi_rd_count;
    logic          resp_start, resp_is_read, resp_done;
    logic [7:0]    resp_status, resp_cmd;
    logic [31:0]   resp_addr;
    logic [5:0]    resp_count;
    logic [BW-1:0] resp_buf_id, buf_release_id;
    logic          buf_release, busy, stats_clear;
    logic [2:0]    queue_level;
    logic [SW-1:0] wr_count, rd_count, err_count;
    logic [7:0]    retry_count;

    bridge_cmd_sequencer #(
        .QUEUE_DEPTH(QD), .BUF_ID_W(BW), .STAT_WIDTH(SW),
        .AXI_WAIT_TIMEOUT(TO), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst(rst),
        .desc_valid_i(desc_valid), .desc_ready_o(desc_ready), .desc_cmd_i(desc_cmd),
        .desc_addr_i(desc_addr), .desc_err_i(desc_err), .desc_err_status_i(desc_err_status),
        .desc_buf_id_i(desc_buf_id),
        .axi_start_o(axi_start), .axi_abort_o(axi_abort), .axi_cmd_o(axi_cmd),
        .axi_addr_o(axi_addr), .axi_buf_id_o(axi_buf_id), .axi_done_i(axi_done),
        .axi_status_i(axi_status), .axi_rd_count_i(axi_rd_count),
        .resp_start_o(resp_start), .resp_status_o(resp_status), .resp_cmd_o(resp_cmd),
        .resp_addr_o(resp_addr), .resp_is_read_o(resp_is_read), .resp_count_o(resp_count),
        .resp_buf_id_o(resp_buf_id), .resp_done_i(resp_done),
        .buf_release_o(buf_release), .buf_release_id_o(buf_release_id),
        .queue_level_o(queue_level), .busy_o(busy), .stats_clear_i(stats_clear),
        .wr_count_o(wr_count), .rd_count_o(rd_count), .err_count_o(err_count),
        .retry_count_o(retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One AXI attempt as the bench responder will answer it.
    typedef struct {
        int          delay;
        bit          tmo;
        logic [7:0]  st;
        logic [5:0]  rc;
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [BW-1:0] id;
    } plan_t;

    // Expected response for one accepted frame.
    typedef struct {
        logic [7:0]    cmd;
        logic [31:0]   addr;
        bit            err;
        logic [7:0]    status;
        logic [5:0]    count;
        logic [BW-1:0] id;
    } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    int    m_wr = 0, m_rd = 0, m_err = 0, m_retry = 0;
    bit    clr_next = 1'b0;
    int    start_cnt = 0, start_cyc = 0, push_cyc = 0;

    function automatic int sat(input int v);
        return (v == (1 << SW) - 1) ? v : v + 1;
    endfunction

    task automatic push_frame(input logic [7:0] cmd, input logic [31:0] addr, input bit err,
                              input logic [7:0] est, input logic [BW-1:0] id, input int delay,
                              input bit tmo, input logic [7:0] st, input logic [5:0] rc);
        plan_t p;
        exp_t  e;
        int    w;
        int    attempts;
        @(posedge clk); #1;
        desc_valid = 1'b1; desc_cmd = cmd; desc_addr = addr; desc_err = err;
        desc_err_status = est; desc_buf_id = id;
        w = 0;
        while (!desc_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check_val("push_accept", desc_ready, 1);
        push_cyc = cyc;
        if (!err) begin
            p = '{delay: delay, tmo: tmo, st: st, rc: rc, cmd: cmd, addr: addr, id: id};
            attempts = 1;
`ifdef BRIDGE_CMD_SEQ_RETRY_EN
            if (tmo) attempts = MR + 1;
`endif
            for (int a = 0; a < attempts; a++) plan_q.push_back(p);
        end
        e.cmd = cmd; e.addr = addr; e.err = err; e.id = id;
        e.status = err ? est : (tmo ? 8'h04 : st);
        e.count  = (!err && !tmo && cmd[7] && st == 8'h00) ? rc : 6'd0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        desc_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || plan_q.size() != 0 || busy !== 1'b0) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_val("drain_busy", busy, 0);
        check_val("drain_pending", exp_q.size(), 0);
    endtask

    // AXI master model: answers each axi_start from the plan queue.
    initial begin
        plan_t p;
        bit    seen;
        axi_done = 1'b0; axi_status = 8'h00; axi_rd_count = 6'd0;
        forever begin
            @(negedge clk);
            if (axi_start === 1'b1) begin
                start_cnt++;
                start_cyc = cyc;
                check_val("axi_start_expected", plan_q.size() != 0, 1);
                if (plan_q.size() != 0) begin
                    p = plan_q.pop_front();
                    check_val("axi_cmd", axi_cmd, p.cmd);
                    check_val("axi_addr", axi_addr, p.addr);
                    check_val("axi_buf_id", axi_buf_id, p.id);
                    if (p.tmo) begin
                        seen = 1'b0;
                        for (int k = 1; k <= TO + 4 && !seen; k++) begin
                            @(negedge clk);
                            if (axi_abort === 1'b1) begin
                                seen = 1'b1;
                                check_val("abort_latency", cyc - start_cyc, TO);
                            end
                        end
                        check_val("abort_seen", seen, 1);
                    end else begin
                        repeat (p.delay) @(posedge clk);
                        #1;
                        axi_done = 1'b1; axi_status = p.st; axi_rd_count = p.rc;
                        @(negedge clk);
                        check_val("no_abort_on_done", axi_abort, 0);
                        @(posedge clk); #1;
                        axi_done = 1'b0; axi_status = 8'($urandom); axi_rd_count = 6'($urandom);
                    end
                end
            end
        end
    end

    // Frame-builder model: checks each response and updates the stats model.
    initial begin
        exp_t e;
        bit   clr;
        resp_done = 1'b0; stats_clear = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_start === 1'b1) begin
                check_val("resp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("resp_status", resp_status, e.status);
                    check_val("resp_count", resp_count, e.count);
                    check_val("resp_is_read", resp_is_read, e.cmd[7] && !e.err);
                    check_val("resp_cmd", resp_cmd, e.cmd);
                    check_val("resp_addr", resp_addr, e.addr);
                    check_val("resp_buf_id", resp_buf_id, e.id);
                    repeat ($urandom_range(1, 4)) @(posedge clk);
                    #1;
                    clr = clr_next;
                    clr_next = 1'b0;
                    resp_done = 1'b1; stats_clear = clr;
                    @(negedge clk);
                    check_val("buf_release", buf_release, 1);
                    check_val("buf_release_id", buf_release_id, e.id);
                    @(posedge clk); #1;
                    resp_done = 1'b0; stats_clear = 1'b0;
                    if (clr) begin
                        m_wr = 0; m_rd = 0; m_err = 0; m_retry = 0;
                    end else if (e.err) begin
                        m_err = sat(m_err);
                    end else begin
                        if (e.cmd[7]) m_rd = sat(m_rd);
                        else          m_wr = sat(m_wr);
                        if (e.status != 8'h00) m_err = sat(m_err);
                    end
                    @(negedge clk);
                    check_val("wr_count", wr_count, m_wr);
                    check_val("rd_count", rd_count, m_rd);
                    check_val("err_count", err_count, m_err);
                    check_val("retry_count", retry_count, m_retry);
                end
            end
        end
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence.
    initial begin
        int s;
        bit tmo;
        logic [7:0] st;
        rst = 1'b1; desc_valid = 1'b0; desc_cmd = 8'h00; desc_addr = 32'h0;
        desc_err = 1'b0; desc_err_status = 8'h00; desc_buf_id = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_desc_ready", desc_ready, 1);
        check_val("rst_queue_level", queue_level, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_axi_start", axi_start, 0);
        check_val("rst_resp_start", resp_start, 0);
        check_val("rst_resp_status", resp_status, 0);
        check_val("rst_counts", {wr_count, rd_count, err_count}, 0);

        // Single write; the nonzero read count must not leak into a write.
        push_frame(8'h00, 32'h1000, 1'b0, 8'h00, 2'd1, 5, 1'b0, 8'h00, 6'h2A);
        wait_idle();
        check_val("start_latency", start_cyc - push_cyc, 2);

        // Read success.
        push_frame(8'h80, 32'h2000, 1'b0, 8'h00, 2'd2, 3, 1'b0, 8'h00, 6'd4);
        wait_idle();

        // Parse error: no AXI access.
        s = start_cnt;
        push_frame(8'h81, 32'h3000, 1'b1, 8'h02, 2'd3, 1, 1'b0, 8'h00, 6'd0);
        wait_idle();
        check_val("perr_no_start", start_cnt, s);

        // Back-to-back: first frame stalls, queue fills up.
        push_frame(8'h01, 32'h4000, 1'b0, 8'h00, 2'd0, 15, 1'b0, 8'h00, 6'd0);
        for (int i = 1; i <= 4; i++)
            push_frame(8'h80 | 8'(i), 32'h4000 + 32'(i), 1'b0, 8'h00, 2'(i), 1, 1'b0, 8'h00, 6'(i));
        check_val("full_level", queue_level, 4);
        check_val("full_ready", desc_ready, 0);
        push_frame(8'h05, 32'h4005, 1'b0, 8'h00, 2'd1, 2, 1'b0, 8'h00, 6'd0);
        wait_idle();
        check_val("drain_level", queue_level, 0);

        // Timeout (re-issued MR times when retries are built in).
        s = start_cnt;
`ifdef BRIDGE_CMD_SEQ_RETRY_EN
        m_retry = m_retry + MR;
`endif
        push_frame(8'h00, 32'h5000, 1'b0, 8'h00, 2'd2, 0, 1'b1, 8'h00, 6'd0);
        wait_idle();
`ifdef BRIDGE_CMD_SEQ_RETRY_EN
        check_val("timeout_starts", start_cnt - s, MR + 1);
`else
        check_val("timeout_starts", start_cnt - s, 1);
`endif

        // Standalone clear, then saturation, then clear coincident with resp_done.
        @(posedge clk); #1 stats_clear = 1'b1;
        @(posedge clk); #1 stats_clear = 1'b0;
        m_wr = 0; m_rd = 0; m_err = 0; m_retry = 0;
        @(negedge clk);
        check_val("clear_counts", {wr_count, rd_count, err_count, retry_count}, 0);
        for (int i = 0; i < 9; i++)
            push_frame(8'h10, 32'h6000 + 32'(i), 1'b0, 8'h00, 2'(i), 1, 1'b0, 8'h00, 6'd0);
        wait_idle();
        check_val("wr_saturated", wr_count, 7);
        clr_next = 1'b1;
        push_frame(8'h11, 32'h7000, 1'b0, 8'h00, 2'd3, 1, 1'b0, 8'h00, 6'd0);
        wait_idle();
        check_val("wr_clear_wins", wr_count, 0);

        // Randomized frames.
        for (int i = 0; i < 40; i++) begin
            tmo = ($urandom_range(0, 9) == 0);
            st  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
`ifdef BRIDGE_CMD_SEQ_RETRY_EN
            tmo = 1'b0;
            st  = 8'h00;
`endif
            push_frame(8'($urandom), $urandom, ($urandom_range(0, 7) == 0), 8'($urandom),
                       BW'($urandom), $urandom_range(1, 6), tmo, st, 6'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_idle();
        check_val("final_level", queue_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
